// File: rtl/mem_block_responder.sv
// Backing-store responder for cache block fills and writebacks: 64K x 16-bit
// memory, fixed access latency, then one 16-bit word per cycle over 8 beats.
module mem_block_responder #(
  parameter int unsigned LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [12:0]  req_blkaddr,
  input  logic [127:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_write,
  output logic [127:0] resp_rdata,
  output logic         busy
);

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned BLK_W     = 13;
  localparam int unsigned BEAT_W    = 3;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned MEM_WORDS = 65536;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;

  state_t              state;
  state_t              state_next;
  logic                ready_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic [BEAT_W-1:0]   beat;
  logic                wr_q;
  logic [BLK_W-1:0]    blk_q;
  logic [BLOCK_W-1:0]  wdata_q;
  logic                accept_c;

  // Backing store starts out cleared and is untouched by rst.
  logic [WORD_W-1:0]   mem [MEM_WORDS] = '{default: '0};

  assign accept_c   = req_valid && ready_q;
  assign req_ready  = ready_q;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_c) state_next = WAIT;
      WAIT: if (wait_cnt == '0) state_next = XFER;
      XFER: if (beat == BEAT_W'(7)) state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is registered so it stays low for the whole cycle after a reset edge.
  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      beat       <= '0;
      wr_q       <= 1'b0;
      blk_q      <= '0;
      wdata_q    <= '0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (accept_c) begin
          wr_q       <= req_write;
          blk_q      <= req_blkaddr;
          wdata_q    <= req_wdata;
          resp_write <= req_write;
          resp_rdata <= '0;
          wait_cnt   <= CNT_W'(LATENCY - 1);
        end
        WAIT: begin
          if (wait_cnt == '0) beat <= '0;
          else                wait_cnt <= wait_cnt - CNT_W'(1);
        end
        XFER: begin
          if (!wr_q) resp_rdata[{beat, 4'd0} +: WORD_W] <= mem[{blk_q, beat}];
          if (beat != BEAT_W'(7)) beat <= beat + BEAT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Writeback beats land one word per cycle; the beat at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && state == XFER && wr_q)
      mem[{blk_q, beat}] <= wdata_q[{beat, 4'd0} +: WORD_W];
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench for mem_block_responder: expected responses are queued at
// request acceptance and compared when the responder presents them.
module tb_mem_block_responder;

  localparam int unsigned LATENCY = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [12:0]  req_blkaddr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_write;
  logic [127:0] resp_rdata;
  logic         busy;

  typedef struct {
    logic         wr;
    logic [127:0] rdata;
  } exp_t;

  exp_t     exp_q[$];
  bit [15:0] model [65536];
  int       n_tests = 0;
  int       n_fail  = 0;

  mem_block_responder #(.LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_blkaddr(req_blkaddr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request, wait for its response, then hold off resp_ready for 'hold' cycles.
  task automatic send(input logic wr, input logic [12:0] blk, input logic [127:0] wd,
                      input int hold);
    exp_t e;
    exp_t got_e;
    int   c;
    e.wr    = wr;
    e.rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (wr) model[{blk, 3'(i)}] = wd[16*i +: 16];
      else    e.rdata[16*i +: 16] = model[{blk, 3'(i)}];
    end
    @(negedge clk);
    c = 0;
    while (!req_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("req_ready_wait", 128'(req_ready), 128'(1));
    req_valid   = 1'b1;
    req_write   = wr;
    req_blkaddr = blk;
    req_wdata   = wd;
    resp_ready  = (hold == 0);
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    req_valid   = 1'b0;
    req_write   = ~wr;
    req_blkaddr = 13'($urandom);
    req_wdata   = {$urandom, $urandom, $urandom, $urandom};
    check("busy_after_accept", 128'(busy), 128'(1));
    check("ready_after_accept", 128'(req_ready), 128'(0));
    c = 0;
    while (!resp_valid && c < 300) begin
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    check("resp_latency", 128'(c), 128'(LATENCY + 8));
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", 128'(resp_valid), 128'(1));
      check("bp_ready", 128'(req_ready), 128'(0));
      if (exp_q.size() > 0) check("bp_rdata", resp_rdata, exp_q[0].rdata);
      req_valid = i[0] ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 128'(0), 128'(1));
    end else begin
      got_e = exp_q.pop_front();
      check("resp_valid", 128'(resp_valid), 128'(1));
      check("resp_write", 128'(resp_write), 128'(got_e.wr));
      check("resp_rdata", resp_rdata, got_e.rdata);
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_resp_valid", 128'(resp_valid), 128'(0));
    check("post_resp_ready", 128'(req_ready), 128'(1));
    check("post_resp_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] wd;
    logic [127:0] exp_rd;
    rst         = 1'b1;
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_blkaddr = 13'h0A5;
    req_wdata   = '1;
    resp_ready  = 1'b0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 128'(req_ready), 128'(0));
      check("rst_resp_valid", 128'(resp_valid), 128'(0));
      check("rst_resp_write", 128'(resp_write), 128'(0));
      check("rst_resp_rdata", resp_rdata, 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 128'(req_ready), 128'(1));
    check("idle_after_rst", 128'(busy), 128'(0));

    // Writeback of 0x1111..0x8888 to block 0x0A5.
    for (int i = 0; i < 8; i++) wd[16*i +: 16] = 16'(16'h1111 * (i + 1));
    send(1'b1, 13'h0A5, wd, 0);
    for (int i = 0; i < 8; i++)
      check("mem_wb", 128'(dut.mem[16'(16'h0528 + i)]), 128'(16'(16'h1111 * (i + 1))));

    // Fill after write, checked against the literal block too.
    send(1'b0, 13'h0A5, '0, 0);
    check("fill_literal", resp_rdata, 128'h8888_7777_6666_5555_4444_3333_2222_1111);

    // Same fill under 5 cycles of response backpressure.
    send(1'b0, 13'h0A5, '0, 5);

    // Writeback to the top block aborted by reset at the beat-3 edge.
    @(negedge clk);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_blkaddr = 13'h1FFF;
    req_wdata   = {8{16'hBEEF}};
    resp_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i < int'(LATENCY) + 4; i++) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid) check("abort_no_resp", 128'(resp_valid), 128'(0));
    end
    check("abort_idle", 128'(busy), 128'(0));
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) model[{13'h1FFF, 3'(i)}] = 16'hBEEF;
    send(1'b0, 13'h1FFF, '0, 0);
    exp_rd = {80'h0, {3{16'hBEEF}}};
    check("abort_fill_literal", resp_rdata, exp_rd);

    // Top-block boundary: no wrap into word 0.
    for (int i = 0; i < 8; i++) wd[16*i +: 16] = 16'(i);
    send(1'b1, 13'h1FFF, wd, 0);
    send(1'b1, 13'h0000, {112'h0, 16'hAAAA}, 2);
    send(1'b0, 13'h1FFF, '0, 0);
    check("boundary_literal", resp_rdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    send(1'b0, 13'h0000, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_block_responder.md
# mem_block_responder

Main-memory responder on the memory side of the 16-bit instruction/data cache's refill and writeback path. It serves one whole-block request at a time: a fill (read) or a writeback (write) of one 8-word, 128-bit cache block. Requests and responses use valid/ready handshakes. The block holds the 64K x 16-bit backing store and models access latency followed by one-word-per-cycle transfer beats.

## Interface
- LATENCY, 4, idle cycles between request acceptance and the first transfer beat (legal range 1..255)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = writeback block, 0 = fill block
- req_blkaddr  in  13  block address (tag[2:0], set[9:0])
- req_wdata  in  128  writeback block; word i is at bits [16i+15:16i]
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts the response
- resp_write  out  1  echoes req_write of the request being answered
- resp_rdata  out  128  fill data in the same word packing as req_wdata; 0 for writebacks
- busy  out  1  high in every state except IDLE

## Operation
- Storage: 65536 x 16-bit words. Word i of block B is at address {B, i[2:0]}. Contents are not affected by rst and are zero at time 0.
- States and transitions:
  - IDLE: req_ready=1. When req_valid&req_ready is sampled, latch req_write, req_blkaddr and req_wdata; clear resp_rdata to 0; load the wait counter with LATENCY-1; go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter is 0, clear the beat counter to 0 and go to XFER.
  - XFER: 8 beats, beat counter k = 0..7, one beat per cycle.
    - Writeback: mem[{B,k}] <= latched wdata word k.
    - Fill: resp_rdata[16k+15:16k] <= mem[{B,k}].
    - After beat 7, go to RESP.
  - RESP: resp_valid=1, with resp_write and resp_rdata held stable. When resp_valid&resp_ready is sampled, go to IDLE.
- Only one request is outstanding at a time. req_ready=0 in WAIT, XFER and RESP. Input changes after acceptance are ignored.
- Counters are 3-bit (beat) and 8-bit (wait). Neither wraps within a request.
- Addressing: block 0x1FFF covers words 0xFFF8..0xFFFF. There is no wrap into block 0.
- Reset:
  - rst sampled high forces IDLE from any state, aborting any request in flight; no response is issued.
  - Writeback beats completed before the reset edge stay in memory; the beat at the reset edge and all later beats are not written.
  - While rst is high, req_ready=0.

## Timing
- Reset values: req_ready=0 (while rst=1, then 1 in the first cycle after release), resp_valid=0, resp_write=0, resp_rdata=0, busy=0.
- Acceptance edge E0 is the edge where req_valid&req_ready is sampled high.
  - WAIT spans edges E1..E_LATENCY.
  - Beat k completes at edge E_(LATENCY+1+k).
  - resp_valid rises after edge E_(LATENCY+8). With LATENCY=4, that is 12 cycles after E0.
- If resp_ready is already high when resp_valid rises, the response completes at the next edge (1 cycle in RESP).
- After the response handshake edge, req_ready=1 in the following cycle. The minimum request-to-request spacing is LATENCY+10 cycles.
- A fill that follows a writeback to the same block returns the written data.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- Reset: hold rst=1 for 2 cycles with req_valid=1 → all outputs 0 and no request accepted; req_ready=1 in the cycle after rst falls.
- Writeback: block 0x0A5, wdata words 0..7 = 0x1111..0x8888 → resp_valid rises 12 cycles after acceptance with resp_write=1 and resp_rdata=0; mem[0x0528..0x052F] = 0x1111..0x8888.
- Fill after write: fill block 0x0A5 → resp_rdata = 0x8888_7777_6666_5555_4444_3333_2222_1111 and resp_write=0.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP while pulsing req_valid → resp_valid and resp_rdata stay stable, req_ready stays 0, and nothing is accepted; handshake occurs on the edge where resp_ready rises.
- Reset mid-transfer: writeback to block 0x1FFF with all words 0xBEEF, rst high at the beat-3 edge → no response; a later fill of 0x1FFF returns words 0..2 = 0xBEEF and words 3..7 = 0x0000.
- Boundary fill: preload mem[0xFFF8..0xFFFF] = 0..7 and mem[0x0000] = 0xAAAA, then fill 0x1FFF → resp_rdata words are 0..7 in order; 0xAAAA does not appear.
